// File: rtl/act_stream_buffer.sv
// Show-ahead FIFO that captures a valid-only activation stream, tags tile boundaries,
// and records elements lost to overflow.
module act_stream_buffer #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int TILE_LEN = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    input  logic                       ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [TW-1:0] TILE_MAX = TW'(TILE_LEN - 1);

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic              r_mem_last [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [TW-1:0]     r_tile_cnt;
    logic              r_overflow;
    logic [15:0]       r_drop_count;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_tile_last;

    assign w_full      = (r_level == FULL_LVL);
    assign w_pop       = (r_level != '0) && out_ready;
    assign w_push      = valid_in && (!w_full || w_pop);
    assign w_drop      = valid_in && w_full && !w_pop;
    assign w_tile_last = (r_tile_cnt == TILE_MAX);

    // Storage is left unreset; only pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (w_push && rst_n) begin
            r_mem_data[r_wr_ptr] <= data_in;
            r_mem_last[r_wr_ptr] <= w_tile_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Tile framing counts every arriving element, dropped or not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tile_cnt <= '0;
        end else if (valid_in) begin
            r_tile_cnt <= w_tile_last ? '0 : r_tile_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (ovf_clr) begin
            r_overflow   <= w_drop;
            r_drop_count <= {15'd0, w_drop};
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign out_valid  = (r_level != '0);
    assign out_data   = r_mem_data[r_rd_ptr];
    assign out_last   = r_mem_last[r_rd_ptr];
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: doc/act_stream_buffer.md
ACT_STREAM_BUFFER -- requirements
Module: act_stream_buffer

Interface
REQ-001 Parameter DATA_W, default 32, element width in bits.
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, >= 2.
REQ-003 Parameter TILE_LEN, default 64, elements per tile; >= 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 valid_in  input  1  element present on data_in this cycle; no backpressure to the producer.
REQ-007 data_in  input  DATA_W  activation-stage output element.
REQ-008 out_valid  output  1  head element available.
REQ-009 out_ready  input  1  consumer accepts head element.
REQ-010 out_data  output  DATA_W  head element.
REQ-011 out_last  output  1  head element closes a tile.
REQ-012 level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 overflow  output  1  sticky; an element was dropped.
REQ-014 drop_count  output  16  dropped elements, saturating.
REQ-015 ovf_clr  input  1  clears overflow and drop_count.

Function
REQ-016 The block shall buffer a valid-only stream into a show-ahead FIFO of DEPTH entries, each entry holding data plus a last tag.
REQ-017 Push = valid_in and (not full, or pop in the same cycle); pop = out_valid and out_ready.
REQ-018 out_valid shall equal (level != 0); out_data/out_last shall reflect the head entry combinationally from storage.
REQ-019 Latency: an element pushed at edge N shall be visible at the output after edge N; no same-cycle bypass when empty.
REQ-020 Simultaneous push and pop shall leave level unchanged, including when full (element accepted, no drop) and when level is 1.
REQ-021 Read/write pointers shall wrap modulo DEPTH; full = (level == DEPTH).
REQ-022 An input tile counter, 0..TILE_LEN-1, shall advance on every valid_in cycle, including dropped ones, wrapping to 0 after TILE_LEN-1.
REQ-023 The last tag stored with an element shall be 1 iff the tile counter equals TILE_LEN-1 at its arrival; TILE_LEN = 1 tags every element.
REQ-024 Drop = valid_in and full and no pop; the element shall not be written, pointers and level unchanged.
REQ-025 On drop, overflow shall be set and drop_count incremented, saturating at 16'hFFFF.
REQ-026 ovf_clr shall clear overflow to 0 and drop_count to 0 on the next edge; ovf_clr coincident with a drop shall yield overflow=1, drop_count=1.
REQ-027 data_in values shall pass bit-exact; no arithmetic on the payload.
REQ-028 out_data/out_last while out_valid=0 are don't-care; out_ready while empty shall have no effect.

Reset
REQ-029 While rst_n=0 at a rising edge: level=0, pointers=0, tile counter=0, overflow=0, drop_count=0, hence out_valid=0.
REQ-030 Reset asserted mid-stream shall discard all buffered entries and restart tile framing at element 0; valid_in during reset shall be ignored and not counted.
REQ-031 FIFO storage need not be reset.

Verification (bench config DEPTH=4, TILE_LEN=3, DATA_W=32)
REQ-032 Pass-through: out_ready=1, push 6 elements 0x1..0x6 one per cycle -> out_data 0x1..0x6 each one cycle after input; out_last=1 on 0x3 and 0x6 only; level never exceeds 1.
REQ-033 Fill/drop: out_ready=0, push 0xA0..0xA5 -> level=4 after 4th push, 0xA4/0xA5 dropped, overflow=1, drop_count=2; then out_ready=1 drains 0xA0..0xA3, out_last on 0xA2 only.
REQ-034 Full with concurrent pop: level=4, valid_in=1 and out_ready=1 same cycle with 0xB0 -> no drop, level stays 4, 0xB0 emerges after the 4 older entries.
REQ-035 Clear vs drop: full, out_ready=0, valid_in=1, ovf_clr=1 in the same cycle after drop_count=2 -> overflow=1, drop_count=1; next cycle ovf_clr=1 alone -> overflow=0, drop_count=0.
REQ-036 Reset mid-operation: level=3 and tile counter=1, pulse rst_n=0 for one edge -> out_valid=0, level=0, overflow=0; next 3 pushes 0xC1..0xC3 tag out_last only on 0xC3.
REQ-037 Saturation: force 65537 drops -> drop_count=16'hFFFF, overflow=1.
